// File: rtl/x2050pswstore_pkg.sv
// rtl/x2050pswstore_pkg.sv - shared 2050 PSW classes, addresses, state and field layout
package x2050pkg;

   localparam logic [2:0] CLS_EXT = 3'd0;
   localparam logic [2:0] CLS_SVC = 3'd1;
   localparam logic [2:0] CLS_PGM = 3'd2;
   localparam logic [2:0] CLS_MCK = 3'd3;
   localparam logic [2:0] CLS_IO  = 3'd4;

   localparam int OLD_SVC = 32;
   localparam int OLD_PGM = 40;
   localparam int OLD_MCK = 48;
   localparam int OLD_IO  = 56;

   localparam int NEW_EXT = 88;
   localparam int NEW_SVC = 96;
   localparam int NEW_PGM = 104;
   localparam int NEW_MCK = 112;
   localparam int NEW_IO  = 120;

   typedef enum logic [1:0] {IDLE, W0, W1, DONE} state_t;

   // LSB positions inside each 32-bit PSW word (IBM bit 0 is the MSB)
   localparam int PSW_SYSMASK_LSB = 24;
   localparam int PSW_KEY_LSB     = 20;
   localparam int PSW_AMWP_LSB    = 16;
   localparam int PSW_CODE_LSB    = 0;
   localparam int PSW_ILC_LSB     = 30;
   localparam int PSW_CC_LSB      = 28;
   localparam int PSW_PMASK_LSB   = 24;
   localparam int PSW_IC_LSB      = 0;

   typedef struct packed {
      logic [7:0]  sysmask;
      logic [3:0]  key;
      logic [3:0]  amwp;
      logic [15:0] int_code;
      logic [1:0]  ilc;
      logic [1:0]  cc;
      logic [3:0]  pmask;
      logic [23:0] ic;
   } psw_fields_t;

   function automatic logic class_valid(input logic [2:0] cls);
      return cls <= CLS_IO;
   endfunction

endpackage

// File: rtl/x2050pswfmt.sv
// rtl/x2050pswfmt.sv - combinational packer from PSW fields to the two 360-format words
module x2050pswfmt
   import x2050pkg::*;
(
   input  psw_fields_t f,
   output logic [31:0] word0,
   output logic [31:0] word1
);

   always_comb begin
      word0 = '0;
      word1 = '0;
      word0[PSW_SYSMASK_LSB +: 8] = f.sysmask;
      word0[PSW_KEY_LSB +: 4]     = f.key;
      word0[PSW_AMWP_LSB +: 4]    = f.amwp;
      word0[PSW_CODE_LSB +: 16]   = f.int_code;
      word1[PSW_ILC_LSB +: 2]     = f.ilc;
      word1[PSW_CC_LSB +: 2]      = f.cc;
      word1[PSW_PMASK_LSB +: 4]   = f.pmask;
      word1[PSW_IC_LSB +: 24]     = f.ic;
   end

endmodule

// File: rtl/x2050pswstore.sv
// rtl/x2050pswstore.sv - store-old-PSW sequencer writing the snapshot doubleword
module x2050pswstore
   import x2050pkg::*;
#(
   parameter int ADDR_W  = 24,
   parameter int EXT_OLD = 24
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_ros_advance,
   input  logic              i_start,
   input  logic [2:0]        i_class,
   input  logic [7:0]        i_sysmask,
   input  logic [3:0]        i_key,
   input  logic [3:0]        i_amwp,
   input  logic [15:0]       i_int_code,
   input  logic [1:0]        i_ilc,
   input  logic [1:0]        i_cc,
   input  logic [3:0]        i_pmask,
   input  logic [23:0]       i_ic,
   output logic              o_wr_valid,
   input  logic              i_wr_ready,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [31:0]       o_wr_data,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   state_t            state, state_nx;
   psw_fields_t       live, snap;
   logic [ADDR_W-1:0] base;
   logic [31:0]       word0, word1;
   logic              take, err_q;

   function automatic logic [ADDR_W-1:0] base_of(input logic [2:0] cls);
      case (cls)
         CLS_EXT: return ADDR_W'(EXT_OLD);
         CLS_SVC: return ADDR_W'(OLD_SVC);
         CLS_PGM: return ADDR_W'(OLD_PGM);
         CLS_MCK: return ADDR_W'(OLD_MCK);
         default: return ADDR_W'(OLD_IO);
      endcase
   endfunction

   assign live = '{sysmask: i_sysmask, key: i_key, amwp: i_amwp, int_code: i_int_code,
                   ilc: i_ilc, cc: i_cc, pmask: i_pmask, ic: i_ic};
   assign take = i_start & i_ros_advance & (state == IDLE);
   assign o_err = err_q;

   x2050pswfmt u_fmt (
      .f     (snap),
      .word0 (word0),
      .word1 (word1)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nx;
   end

   // Only the snapshot feeds the packer, so live fields may move freely once started
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         snap  <= '0;
         base  <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= take & ~class_valid(i_class);
         if (take && class_valid(i_class)) begin
            snap <= live;
            base <= base_of(i_class);
         end
      end
   end

   always_comb begin
      state_nx   = state;
      o_wr_valid = 1'b0;
      o_wr_addr  = '0;
      o_wr_data  = '0;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      case (state)
         IDLE: if (take && class_valid(i_class)) state_nx = W0;
         W0: begin
            o_busy     = 1'b1;
            o_wr_valid = 1'b1;
            o_wr_addr  = base;
            o_wr_data  = word0;
            if (i_wr_ready) state_nx = W1;
         end
         W1: begin
            o_busy     = 1'b1;
            o_wr_valid = 1'b1;
            o_wr_addr  = base + ADDR_W'(4);
            o_wr_data  = word1;
            if (i_wr_ready) state_nx = DONE;
         end
         DONE: begin
            o_busy   = 1'b1;
            o_done   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
